// File: rtl/id_decode_stage_if.sv
// Fetch-to-decode link: instruction/address forward,
// branch redirect and stall back to fetch.
interface id_decode_stage_if;
  logic [15:0] id_instr;
  logic [15:0] id_instr_addr;
  logic        BRANCH;
  logic        STALL;
  logic [15:0] branch_instr_addr;

  modport master (
    output id_instr, id_instr_addr,
    input  BRANCH, STALL, branch_instr_addr
  );

  modport slave (
    input  id_instr, id_instr_addr,
    output BRANCH, STALL, branch_instr_addr
  );
endinterface

// File: rtl/id_decode_stage.sv
// Decode/issue stage: regfile, scoreboard, branch resolve, ID/EX reg.
// Ports: CLOCK_50, reset(n), fetch(slave), wb_*, ex_*.
module id_decode_stage #(
  parameter int          SQUASH_DEPTH = 2,
  parameter logic [15:0] RESET_PC     = 16'd8
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  id_decode_stage_if.slave   fetch,
  input  logic               wb_en,
  input  logic [3:0]         wb_rd,
  input  logic [15:0]        wb_data,
  output logic               ex_valid,
  output logic [3:0]         ex_op,
  output logic [3:0]         ex_rd,
  output logic [15:0]        ex_a,
  output logic [15:0]        ex_b,
  output logic [15:0]        ex_imm,
  output logic [15:0]        ex_instr_addr
);

  localparam int CW = $clog2(SQUASH_DEPTH + 1);

  logic [15:0]   regs [16];
  logic [15:0]   pending;
  logic [CW-1:0] squash_cnt;

  logic [3:0]  op, rd, rs, rt;
  logic [15:0] imm_x;
  logic [15:0] v_rd, v_rs, v_rt;
  logic [15:0] wb_clr, busy;

  assign op    = fetch.id_instr[15:12];
  assign rd    = fetch.id_instr[11:8];
  assign rs    = fetch.id_instr[7:4];
  assign rt    = fetch.id_instr[3:0];
  assign imm_x = {{12{rt[3]}}, rt};

  // Writeback this cycle makes a register readable and no longer busy.
  assign wb_clr = wb_en ? (16'b1 << wb_rd) : '0;
  assign busy   = pending & ~wb_clr;

  assign v_rd = (rd == 4'd0) ? '0 :
                (wb_en && wb_rd == rd) ? wb_data : regs[rd];
  assign v_rs = (rs == 4'd0) ? '0 :
                (wb_en && wb_rd == rs) ? wb_data : regs[rs];
  assign v_rt = (rt == 4'd0) ? '0 :
                (wb_en && wb_rd == rt) ? wb_data : regs[rt];

  logic use_rs, use_rt, use_rd;
  logic is_alu, is_sw, is_beq, is_bne, is_jmp, writer;

  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    use_rd = 1'b0;
    is_alu = 1'b0;
    is_sw  = 1'b0;
    is_beq = 1'b0;
    is_bne = 1'b0;
    is_jmp = 1'b0;
    unique case (op)
      4'h1, 4'h2, 4'h3, 4'h4: begin
        is_alu = 1'b1;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      4'h5, 4'h6: use_rs = 1'b1;
      4'h7: begin
        is_sw  = 1'b1;
        use_rs = 1'b1;
        use_rd = 1'b1;
      end
      4'h8: begin
        is_beq = 1'b1;
        use_rs = 1'b1;
        use_rd = 1'b1;
      end
      4'h9: begin
        is_bne = 1'b1;
        use_rs = 1'b1;
        use_rd = 1'b1;
      end
      4'hA:    is_jmp = 1'b1;
      default: ;
    endcase
  end

  assign writer = (op >= 4'h1) && (op <= 4'h6) && (rd != 4'd0);

  logic hazard, squashing, go, taken, issue;
  logic [15:0] br_tgt;

  assign hazard = (use_rs & busy[rs]) | (use_rt & busy[rt]) |
                  ((use_rd | writer) & busy[rd]);
  assign squashing = (squash_cnt != '0);
  assign go        = !squashing && !hazard;
  assign taken     = go && (is_jmp ||
                     (is_beq && v_rd == v_rs) ||
                     (is_bne && v_rd != v_rs));
  assign issue     = go && !(is_beq || is_bne || is_jmp);

  assign br_tgt = is_jmp ? {fetch.id_instr_addr[15:12], fetch.id_instr[11:0]}
                         : fetch.id_instr_addr + 16'd1 + imm_x;

  assign fetch.STALL  = !squashing && hazard;
  assign fetch.BRANCH = taken;
  assign fetch.branch_instr_addr = taken ? br_tgt : RESET_PC;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (wb_en && wb_rd != 4'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Set wins over a same-cycle clear of the same register.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      pending    <= '0;
      squash_cnt <= CW'(SQUASH_DEPTH);
    end else begin
      pending <= (pending & ~wb_clr) |
                 ((issue && writer) ? (16'b1 << rd) : '0);
      if (taken)
        squash_cnt <= CW'(SQUASH_DEPTH);
      else if (squashing)
        squash_cnt <= squash_cnt - 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      ex_valid      <= 1'b0;
      ex_op         <= '0;
      ex_rd         <= '0;
      ex_a          <= '0;
      ex_b          <= '0;
      ex_imm        <= '0;
      ex_instr_addr <= '0;
    end else begin
      ex_valid <= issue;
      if (issue) begin
        ex_op         <= (op > 4'hA) ? 4'h0 : op;
        ex_rd         <= rd;
        ex_a          <= v_rs;
        ex_b          <= is_alu ? v_rt : (is_sw ? v_rd : 16'h0);
        ex_imm        <= imm_x;
        ex_instr_addr <= fetch.id_instr_addr;
      end
    end
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: directed literal cases plus
// random traffic against an architectural model.
module tb_id_decode_stage;

  localparam logic [15:0] RPC = 16'd8;
  localparam int          SQD = 2;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        ex_valid;
  logic [3:0]  ex_op, ex_rd;
  logic [15:0] ex_a, ex_b, ex_imm, ex_instr_addr;

  id_decode_stage_if fi ();

  id_decode_stage dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .fetch         (fi),
    .wb_en         (wb_en),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .ex_valid      (ex_valid),
    .ex_op         (ex_op),
    .ex_rd         (ex_rd),
    .ex_a          (ex_a),
    .ex_b          (ex_b),
    .ex_imm        (ex_imm),
    .ex_instr_addr (ex_instr_addr)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] m_R [16];
  bit          m_pend [16];
  int          m_sq;

  logic        l_stall, l_branch;
  logic [15:0] l_addr;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_R[i]    = '0;
      m_pend[i] = 1'b0;
    end
    m_sq = SQD;
  endtask

  function automatic bit mbusy(input logic [3:0] r, input logic we,
                               input logic [3:0] wr);
    return m_pend[r] && !(we && wr == r);
  endfunction

  function automatic logic [15:0] mrd(input logic [3:0] r,
      input logic we, input logic [3:0] wr, input logic [15:0] wd);
    if (r == 0) return 16'h0;
    if (we && wr == r) return wd;
    return m_R[r];
  endfunction

  // One cycle: drive, check combinational outputs, clock, check ID/EX.
  task automatic step(input logic [15:0] ins, input logic [15:0] adr,
                      input logic we, input logic [3:0] wr,
                      input logic [15:0] wd);
    logic [3:0]  op, rd, rs, rt;
    logic [15:0] sx, a_rd, a_rs, a_rt, tgt, e_b;
    bit sq, hz, wrt, isbr, tk, iss;
    fi.id_instr      = ins;
    fi.id_instr_addr = adr;
    wb_en   = we;
    wb_rd   = wr;
    wb_data = wd;
    #1;
    op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
    sx   = {{12{rt[3]}}, rt};
    a_rd = mrd(rd, we, wr, wd);
    a_rs = mrd(rs, we, wr, wd);
    a_rt = mrd(rt, we, wr, wd);
    sq   = (m_sq > 0);
    hz   = 1'b0;
    if (op inside {[4'h1:4'h4]}) hz = mbusy(rs, we, wr) || mbusy(rt, we, wr);
    else if (op inside {4'h5, 4'h6}) hz = mbusy(rs, we, wr);
    else if (op inside {4'h7, 4'h8, 4'h9})
      hz = mbusy(rd, we, wr) || mbusy(rs, we, wr);
    wrt = (op inside {[4'h1:4'h6]}) && rd != 0;
    if (wrt && mbusy(rd, we, wr)) hz = 1'b1;
    isbr = op inside {4'h8, 4'h9, 4'hA};
    tk   = !sq && !hz && (op == 4'hA ||
           (op == 4'h8 && a_rd == a_rs) || (op == 4'h9 && a_rd != a_rs));
    tgt  = (op == 4'hA) ? {adr[15:12], ins[11:0]} : 16'(adr + 1 + sx);
    iss  = !sq && !hz && !isbr;
    e_b  = (op inside {[4'h1:4'h4]}) ? a_rt : a_rd;
    l_stall  = fi.STALL;
    l_branch = fi.BRANCH;
    l_addr   = fi.branch_instr_addr;
    chk("stall", l_stall, !sq && hz);
    chk("branch", l_branch, tk);
    chk("br_addr", l_addr, tk ? tgt : RPC);
    @(posedge CLOCK_50);
    if (we && wr != 0) begin
      m_R[wr]    = wd;
      m_pend[wr] = 1'b0;
    end
    if (iss && wrt) m_pend[rd] = 1'b1;
    if (tk) m_sq = SQD;
    else if (m_sq > 0) m_sq--;
    #1;
    chk("ex_valid", ex_valid, iss);
    if (iss) begin
      chk("ex_op", ex_op, (op > 4'hA) ? 4'h0 : op);
      chk("ex_rd", ex_rd, rd);
      chk("ex_a", ex_a, a_rs);
      chk("ex_imm", ex_imm, sx);
      chk("ex_addr", ex_instr_addr, adr);
      if (op inside {[4'h1:4'h4], 4'h7}) chk("ex_b", ex_b, e_b);
    end
    @(negedge CLOCK_50);
  endtask

  initial begin
    logic [15:0] ins, adr;
    logic        we;
    logic [3:0]  wr;
    int          np;
    logic [3:0]  plist [16];

    reset = 1'b0;
    fi.id_instr = 16'h1123;
    fi.id_instr_addr = 16'h0;
    wb_en = 0; wb_rd = 0; wb_data = 0;
    model_reset();
    repeat (2) @(negedge CLOCK_50);
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_stall", fi.STALL, 1'b0);
    chk("rst_branch", fi.BRANCH, 1'b0);
    chk("rst_baddr", fi.branch_instr_addr, 16'h0008);
    chk("rst_ex", {ex_op, ex_rd, ex_a, ex_b, ex_imm, ex_instr_addr}, '0);
    reset = 1'b1;

    step(16'h1123, 16'h0000, 0, 0, 0);
    chk("sq_slot1", ex_valid, 1'b0);
    step(16'h1123, 16'h0000, 0, 0, 0);
    chk("sq_slot2", ex_valid, 1'b0);
    step(16'h1123, 16'h0000, 0, 0, 0);
    chk("first_issue", {ex_valid, ex_op, ex_rd}, {1'b1, 4'h1, 4'h1});

    step(16'h2415, 16'h0001, 0, 0, 0);
    chk("raw_stall1", l_stall, 1'b1);
    step(16'h2415, 16'h0001, 0, 0, 0);
    chk("raw_stall2", l_stall, 1'b1);
    step(16'h2415, 16'h0001, 1, 4'd1, 16'h0005);
    chk("raw_release", l_stall, 1'b0);
    chk("raw_bypass", ex_a, 16'h0005);

    step(16'h0000, 16'h0002, 1, 4'd2, 16'h00AA);
    step(16'h0000, 16'h0003, 1, 4'd3, 16'h00AA);
    step(16'h0000, 16'h0004, 1, 4'd4, 16'h1234);
    step(16'h823F, 16'h0010, 0, 0, 0);
    chk("beq_taken", l_branch, 1'b1);
    chk("beq_target", l_addr, 16'h0010);
    chk("beq_noissue", ex_valid, 1'b0);
    step(16'h0000, 16'h0010, 0, 0, 0);
    chk("beq_sq1", ex_valid, 1'b0);
    step(16'h0000, 16'h0011, 0, 0, 0);
    chk("beq_sq2", ex_valid, 1'b0);
    step(16'h0000, 16'h0012, 0, 0, 0);
    chk("beq_after", ex_valid, 1'b1);

    step(16'h9232, 16'h0020, 0, 0, 0);
    chk("bne_nt", {l_branch, l_addr, ex_valid}, {1'b0, RPC, 1'b0});
    step(16'h0000, 16'h0021, 0, 0, 0);
    chk("bne_next", ex_valid, 1'b1);

    step(16'hA123, 16'hF004, 0, 0, 0);
    chk("jmp", {l_branch, l_addr}, {1'b1, 16'hF123});
    step(16'h0000, 16'hF123, 0, 0, 0);
    step(16'h0000, 16'hF124, 0, 0, 0);
    step(16'h0000, 16'h0030, 1, 4'd0, 16'hFFFF);
    chk("r0_bypass", {ex_valid, ex_a}, {1'b1, 16'h0000});
    step(16'h1000, 16'h0031, 0, 0, 0);
    chk("r0_read", {ex_valid, ex_a}, {1'b1, 16'h0000});

    step(16'h5400, 16'h0040, 0, 0, 0);
    step(16'h1044, 16'h0041, 0, 0, 0);
    chk("pre_rst_stall", l_stall, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_stall", fi.STALL, 1'b0);
    chk("mid_rst_ex", {ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_imm,
                       ex_instr_addr}, '0);
    model_reset();
    @(negedge CLOCK_50);
    reset = 1'b1;
    step(16'h1044, 16'h0041, 0, 0, 0);
    step(16'h1044, 16'h0041, 0, 0, 0);
    step(16'h1044, 16'h0041, 0, 0, 0);
    chk("pend_cleared", {l_stall, ex_valid}, {1'b0, 1'b1});

    ins = 16'h0; adr = 16'h0;
    for (int n = 0; n < 3000; n++) begin
      if (!l_stall) begin
        ins = 16'($urandom);
        adr = 16'($urandom);
      end
      we = ($urandom_range(0, 1) == 1);
      np = 0;
      for (int r = 0; r < 16; r++)
        if (m_pend[r]) begin
          plist[np] = 4'(r);
          np++;
        end
      if (np > 0 && $urandom_range(0, 9) < 7)
        wr = plist[$urandom_range(0, np - 1)];
      else
        wr = 4'($urandom);
      step(ins, adr, we, wr, 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
